sdram_cmd_arbiter: RTL and testbench

SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

---
 rtl/sdram_cmd_arbiter_pkg.sv | 27 ++
 rtl/sdram_arb_tag_fifo.sv | 54 +++++
 rtl/sdram_cmd_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_cmd_arbiter_pkg.sv
// Shared types, constants and helpers for the SDRAM command arbiter.
// Also carries the build-wide defaults for command width and tag FIFO depth.
`ifndef SDRAM_CMD_FIFO_DATA_WIDTH
`define SDRAM_CMD_FIFO_DATA_WIDTH 32
`endif
`ifndef SDRAM_ARB_TAG_DEPTH
`define SDRAM_ARB_TAG_DEPTH 8
`endif

package sdram_cmd_arbiter_pkg;

   localparam int unsigned DataWidth = 32;
   localparam int unsigned NumReq    = 2;

   typedef enum logic {
      ReqR0 = 1'b0,
      ReqR1 = 1'b1
   } req_id_e;

   // A write needs room in both SDRAM-side FIFOs; a read needs a free tag slot.
   function automatic logic req_eligible(input logic req, input logic write,
                                         input logic cfifo_full, input logic wfifo_full,
                                         input logic tag_full);
      return req & ~cfifo_full & (write ? ~wfifo_full : ~tag_full);
   endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO: 1-bit requester IDs of outstanding reads, synchronous show-ahead.
// Push is ignored when full, pop is ignored when empty.
module sdram_arb_tag_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic push,
   input  logic push_data,
   input  logic pop,
   output logic pop_data,
   output logic full,
   output logic empty
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] mem_q;
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == (PtrW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem_q[rd_ptr_q];

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PtrW+1)'(1);
            2'b01:   count_q <= count_q - (PtrW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Two-requester SDRAM command arbiter with in-order read-data return via a tag FIFO.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module sdram_cmd_arbiter
   import sdram_cmd_arbiter_pkg::*;
#(
   parameter int unsigned CMD_WIDTH = `SDRAM_CMD_FIFO_DATA_WIDTH,
   parameter int unsigned TAG_DEPTH = `SDRAM_ARB_TAG_DEPTH
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,

   input  logic                 R0_REQ,
   input  logic                 R0_WRITE,
   input  logic [CMD_WIDTH-1:0] R0_CMD,
   input  logic [DataWidth-1:0] R0_WDATA,
   output logic                 R0_ACK,
   output logic                 R0_RVALID,
   output logic [DataWidth-1:0] R0_RDATA,

   input  logic                 R1_REQ,
   input  logic                 R1_WRITE,
   input  logic [CMD_WIDTH-1:0] R1_CMD,
   input  logic [DataWidth-1:0] R1_WDATA,
   output logic                 R1_ACK,
   output logic                 R1_RVALID,
   output logic [DataWidth-1:0] R1_RDATA,

   output logic                 CFIFO_WEN,
   output logic [CMD_WIDTH-1:0] CFIFO_WDATA,
   input  logic                 CFIFO_WFULL,

   output logic                 WFIFO_WEN,
   output logic [DataWidth-1:0] WFIFO_WDATA,
   input  logic                 WFIFO_WFULL,

   output logic                 RFIFO_REN,
   input  logic [DataWidth-1:0] RFIFO_RDATA,
   input  logic                 RFIFO_REMPTY
);

   logic [NumReq-1:0]    elig;
   logic [NumReq-1:0]    grant;
   logic                 grant_write;
   logic                 tag_push;
   req_id_e              tag_push_id;
   logic                 tag_head;
   logic                 tag_full;
   logic                 tag_empty;
   logic [NumReq-1:0]    rvalid_d, rvalid_q;
   logic [DataWidth-1:0] rdata0_d, rdata0_q;
   logic [DataWidth-1:0] rdata1_d, rdata1_q;

   always_comb begin
      elig[0] = req_eligible(R0_REQ, R0_WRITE, CFIFO_WFULL, WFIFO_WFULL, tag_full);
      elig[1] = req_eligible(R1_REQ, R1_WRITE, CFIFO_WFULL, WFIFO_WFULL, tag_full);
   end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   assign grant[0] = HRESETn & elig[0];
`else
   // High when requester 1 received the most recent grant.
   logic last_grant_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         last_grant_q <= 1'b1;
      end else if (|grant) begin
         last_grant_q <= grant[1];
      end
   end

   assign grant[0] = HRESETn & elig[0] & (~elig[1] | last_grant_q);
`endif

   assign grant[1] = HRESETn & elig[1] & ~grant[0];

   assign R0_ACK = grant[0];
   assign R1_ACK = grant[1];

   // Command and write-data muxes; the enables decide whether anything is written.
   assign grant_write = grant[1] ? R1_WRITE : R0_WRITE;
   assign CFIFO_WEN   = |grant;
   assign CFIFO_WDATA = grant[1] ? R1_CMD : R0_CMD;
   assign WFIFO_WEN   = (grant[0] & R0_WRITE) | (grant[1] & R1_WRITE);
   assign WFIFO_WDATA = grant[1] ? R1_WDATA : R0_WDATA;

   assign tag_push    = (|grant) & ~grant_write;
   assign tag_push_id = grant[1] ? ReqR1 : ReqR0;

   sdram_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .push      (tag_push),
      .push_data (tag_push_id),
      .pop       (RFIFO_REN),
      .pop_data  (tag_head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   // Data arriving without an outstanding tag is left in the read FIFO.
   assign RFIFO_REN = HRESETn & ~RFIFO_REMPTY & ~tag_empty;

   always_comb begin
      rvalid_d    = '0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      if (RFIFO_REN) begin
         if (tag_head == ReqR1) begin
            rvalid_d[1] = 1'b1;
            rdata1_d    = RFIFO_RDATA;
         end else begin
            rvalid_d[0] = 1'b1;
            rdata0_d    = RFIFO_RDATA;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rvalid_q <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign R0_RVALID = rvalid_q[0];
   assign R1_RVALID = rvalid_q[1];
   assign R0_RDATA  = rdata0_q;
   assign R1_RDATA  = rdata1_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Self-checking bench for sdram_cmd_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sdram_cmd_arbiter;

   localparam int unsigned CmdW  = 32;
   localparam int unsigned Depth = 8;

   logic            HCLK = 1'b0;
   logic            HRESETn;
   logic            R0_REQ, R0_WRITE, R1_REQ, R1_WRITE;
   logic [CmdW-1:0] R0_CMD, R1_CMD;
   logic [31:0]     R0_WDATA, R1_WDATA;
   logic            R0_ACK, R1_ACK, R0_RVALID, R1_RVALID;
   logic [31:0]     R0_RDATA, R1_RDATA;
   logic            CFIFO_WEN, CFIFO_WFULL, WFIFO_WEN, WFIFO_WFULL;
   logic [CmdW-1:0] CFIFO_WDATA;
   logic [31:0]     WFIFO_WDATA, RFIFO_RDATA;
   logic            RFIFO_REN, RFIFO_REMPTY;

   always #5 HCLK = ~HCLK;

   sdram_cmd_arbiter #(
      .CMD_WIDTH (CmdW),
      .TAG_DEPTH (Depth)
   ) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .R0_REQ       (R0_REQ),
      .R0_WRITE     (R0_WRITE),
      .R0_CMD       (R0_CMD),
      .R0_WDATA     (R0_WDATA),
      .R0_ACK       (R0_ACK),
      .R0_RVALID    (R0_RVALID),
      .R0_RDATA     (R0_RDATA),
      .R1_REQ       (R1_REQ),
      .R1_WRITE     (R1_WRITE),
      .R1_CMD       (R1_CMD),
      .R1_WDATA     (R1_WDATA),
      .R1_ACK       (R1_ACK),
      .R1_RVALID    (R1_RVALID),
      .R1_RDATA     (R1_RDATA),
      .CFIFO_WEN    (CFIFO_WEN),
      .CFIFO_WDATA  (CFIFO_WDATA),
      .CFIFO_WFULL  (CFIFO_WFULL),
      .WFIFO_WEN    (WFIFO_WEN),
      .WFIFO_WDATA  (WFIFO_WDATA),
      .WFIFO_WFULL  (WFIFO_WFULL),
      .RFIFO_REN    (RFIFO_REN),
      .RFIFO_RDATA  (RFIFO_RDATA),
      .RFIFO_REMPTY (RFIFO_REMPTY)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outstanding read owners in issue order, who was granted last,
   // and what the registered read-return outputs should show this cycle.
   bit          m_tags[$];
   bit          m_last = 1'b1;
   bit          m_rv0, m_rv1;
   logic [31:0] m_rd0, m_rd1;

   always @(negedge HCLK) begin
      bit e0, e1, w0, w1, tfull, ren, t;
      if (!HRESETn) begin
         chk("m_rst_ack0", R0_ACK, 0);
         chk("m_rst_ack1", R1_ACK, 0);
         chk("m_rst_cwen", CFIFO_WEN, 0);
         chk("m_rst_wwen", WFIFO_WEN, 0);
         chk("m_rst_ren", RFIFO_REN, 0);
         chk("m_rst_rv", {R1_RVALID, R0_RVALID}, 0);
         m_tags.delete();
         m_last = 1'b1;
         m_rv0  = 1'b0;
         m_rv1  = 1'b0;
      end else begin
         chk("m_rvalid0", R0_RVALID, m_rv0);
         chk("m_rvalid1", R1_RVALID, m_rv1);
         if (m_rv0) chk("m_rdata0", R0_RDATA, m_rd0);
         if (m_rv1) chk("m_rdata1", R1_RDATA, m_rd1);

         tfull = (m_tags.size() == Depth);
         e0 = R0_REQ && !CFIFO_WFULL && (R0_WRITE ? !WFIFO_WFULL : !tfull);
         e1 = R1_REQ && !CFIFO_WFULL && (R1_WRITE ? !WFIFO_WFULL : !tfull);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
         w0 = e0;
`else
         w0 = e0 && (!e1 || m_last);
`endif
         w1 = e1 && !w0;
         ren = !RFIFO_REMPTY && (m_tags.size() > 0);

         chk("m_ack0", R0_ACK, w0);
         chk("m_ack1", R1_ACK, w1);
         chk("m_cwen", CFIFO_WEN, w0 || w1);
         chk("m_wwen", WFIFO_WEN, (w0 && R0_WRITE) || (w1 && R1_WRITE));
         chk("m_ren", RFIFO_REN, ren);
         if (w0) chk("m_cdata0", CFIFO_WDATA, R0_CMD);
         if (w1) chk("m_cdata1", CFIFO_WDATA, R1_CMD);
         if (w0 && R0_WRITE) chk("m_wdata0", WFIFO_WDATA, R0_WDATA);
         if (w1 && R1_WRITE) chk("m_wdata1", WFIFO_WDATA, R1_WDATA);

         m_rv0 = 1'b0;
         m_rv1 = 1'b0;
         if (ren) begin
            t = m_tags.pop_front();
            if (t) begin m_rv1 = 1'b1; m_rd1 = RFIFO_RDATA; end
            else   begin m_rv0 = 1'b1; m_rd0 = RFIFO_RDATA; end
         end
         if (w0) begin
            if (!R0_WRITE) m_tags.push_back(1'b0);
            m_last = 1'b0;
         end
         if (w1) begin
            if (!R1_WRITE) m_tags.push_back(1'b1);
            m_last = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drain(input int n, input logic [31:0] base);
      RFIFO_REMPTY = 1'b0;
      for (int i = 0; i < n; i++) begin
         RFIFO_RDATA = base + 32'(i);
         step();
      end
      RFIFO_REMPTY = 1'b1;
   endtask

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   bit exp_rr0[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
   bit exp_rr0[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif

   initial begin
      HRESETn      = 1'b0;
      R0_REQ = 0; R0_WRITE = 0; R0_CMD = '0; R0_WDATA = '0;
      R1_REQ = 0; R1_WRITE = 0; R1_CMD = '0; R1_WDATA = '0;
      CFIFO_WFULL  = 1'b0;
      WFIFO_WFULL  = 1'b0;
      RFIFO_REMPTY = 1'b1;
      RFIFO_RDATA  = '0;

      // Requests and read data present during reset must be ignored.
      R0_REQ = 1'b1;
      RFIFO_REMPTY = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_ack0", R0_ACK, 0);
      chk("rst_cwen", CFIFO_WEN, 0);
      chk("rst_ren", RFIFO_REN, 0);
      R0_REQ = 1'b0;
      RFIFO_REMPTY = 1'b1;
      HRESETn = 1'b1;
      step();

      // Both requesters reading continuously for four cycles.
      R0_REQ = 1; R1_REQ = 1; R0_CMD = 32'h200; R1_CMD = 32'h201;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_ack0", R0_ACK, exp_rr0[i]);
         chk("rr_ack1", R1_ACK, !exp_rr0[i]);
         step();
      end
      R0_REQ = 0; R1_REQ = 0;
      drain(4, 32'hA000_0000);
      step();

      // Single write with empty FIFOs.
      R0_REQ = 1; R0_WRITE = 1; R0_CMD = 32'h100; R0_WDATA = 32'hDEAD_BEEF;
      #1;
      chk("wr_ack0", R0_ACK, 1);
      chk("wr_cwen", CFIFO_WEN, 1);
      chk("wr_wwen", WFIFO_WEN, 1);
      chk("wr_cdata", CFIFO_WDATA, 32'h100);
      chk("wr_wdata", WFIFO_WDATA, 32'hDEAD_BEEF);
      step();
      R0_REQ = 0; R0_WRITE = 0;
      step();

      // R1 read then R0 read; data returns in issue order.
      R1_REQ = 1; R1_CMD = 32'h300;
      #1 chk("ord_ack1", R1_ACK, 1);
      step();
      R1_REQ = 0; R0_REQ = 1; R0_CMD = 32'h301;
      #1 chk("ord_ack0", R0_ACK, 1);
      step();
      R0_REQ = 0; RFIFO_REMPTY = 0; RFIFO_RDATA = 32'h1111_1111;
      #1 chk("ord_ren", RFIFO_REN, 1);
      step();
      RFIFO_RDATA = 32'h2222_2222;
      #1;
      chk("ord_rv1", R1_RVALID, 1);
      chk("ord_rd1", R1_RDATA, 32'h1111_1111);
      chk("ord_rv0_lo", R0_RVALID, 0);
      step();
      RFIFO_REMPTY = 1;
      #1;
      chk("ord_rv0", R0_RVALID, 1);
      chk("ord_rd0", R0_RDATA, 32'h2222_2222);
      chk("ord_rv1_lo", R1_RVALID, 0);
      step();

      // Fill the tag FIFO; the ninth read waits for a pop, and a full FIFO still
      // blocks the push in the pop cycle.
      R0_REQ = 1; R0_CMD = 32'h400;
      for (int i = 0; i < 8; i++) begin
         #1 chk("fill_ack", R0_ACK, 1);
         step();
      end
      #1;
      chk("full_ack", R0_ACK, 0);
      chk("full_cwen", CFIFO_WEN, 0);
      step();
      RFIFO_REMPTY = 0; RFIFO_RDATA = 32'h3333_3333;
      #1;
      chk("full_ren", RFIFO_REN, 1);
      chk("full_pop_ack", R0_ACK, 0);
      step();
      RFIFO_REMPTY = 1;
      #1 chk("full_next_ack", R0_ACK, 1);
      step();
      R0_REQ = 0;
      drain(8, 32'h4000_0000);
      step();

      // Write-data FIFO full: only the read goes through.
      WFIFO_WFULL = 1;
      R0_REQ = 1; R0_WRITE = 1; R0_CMD = 32'h500; R0_WDATA = 32'h5555_5555;
      R1_REQ = 1; R1_WRITE = 0; R1_CMD = 32'h501;
      #1;
      chk("wfull_ack0", R0_ACK, 0);
      chk("wfull_ack1", R1_ACK, 1);
      chk("wfull_wwen", WFIFO_WEN, 0);
      chk("wfull_cdata", CFIFO_WDATA, 32'h501);
      step();
      R0_REQ = 0; R0_WRITE = 0; R1_REQ = 0; WFIFO_WFULL = 0;
      drain(1, 32'h5000_0000);
      step();

      // Reset with reads outstanding and a read return on the outputs.
      R1_REQ = 1; R1_CMD = 32'h600;
      repeat (4) step();
      R1_REQ = 0; RFIFO_REMPTY = 0; RFIFO_RDATA = 32'h6666_6666;
      step();
      RFIFO_REMPTY = 1;
      #1 chk("prerst_rv1", R1_RVALID, 1);
      HRESETn = 0;
      #1;
      chk("rst_rv1", R1_RVALID, 0);
      chk("rst_rd1", R1_RDATA, 0);
      step();
      step();
      HRESETn = 1;
      step();
      RFIFO_REMPTY = 0; RFIFO_RDATA = 32'h7777_7777;
      #1 chk("postrst_ren", RFIFO_REN, 0);
      step();
      RFIFO_REMPTY = 1;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
